// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op/state enums, op predicates and wide
// negate/magnitude helpers shared by the multiply/divide unit.
package muldiv_pkg;

  // Helpers work on a wide word and callers truncate;
  // covers XLEN up to 128 (2*XLEN accumulator).
  localparam int unsigned MD_MAXW = 256;

  typedef logic [MD_MAXW-1:0] md_word_t;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } muldiv_state_e;

  function automatic logic is_div(input muldiv_op_e op);
    return op[2];
  endfunction

  function automatic logic is_rem(input muldiv_op_e op);
    return op[2] & op[1];
  endfunction

  // MUL keeps only the low half, which is
  // sign-agnostic, so it runs unsigned.
  function automatic logic is_signed_a(input muldiv_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_signed_b(input muldiv_op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

  function automatic md_word_t md_neg(input md_word_t v);
    return -v;
  endfunction

  function automatic md_word_t md_mag(input md_word_t v,
                                      input logic neg);
    return neg ? md_neg(v) : v;
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV M-extension mul/div (1 bit/cycle).
// Ports: valid_i/ready_o req, op_i a_i b_i tag_i, flush_i, valid_o/ready_i result_o tag_o.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 64,
  parameter int unsigned TAGW = 5
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [TAGW-1:0] tag_i,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic [TAGW-1:0] tag_o
);

  localparam int unsigned CW = $clog2(XLEN + 1);
  localparam int unsigned W2 = 2 * XLEN;
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  muldiv_state_e   state_q;
  muldiv_op_e      op_q;
  logic [TAGW-1:0] tag_q;
  logic [CW-1:0]   cnt_q;
  logic [W2-1:0]   acc_q;
  logic [XLEN-1:0] dvs_q;
  logic            neg_q;
  logic [XLEN-1:0] result_q;

  muldiv_op_e      op_e;
  logic            sa, sb, a_neg, b_neg;
  logic            div_op, rem_op;
  logic            div_zero, ovf, special;
  logic            res_neg;
  logic [XLEN-1:0] a_mag, b_mag, spec_res;

  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_sh, div_diff;
  logic [W2-1:0]   acc_d;
  logic [W2-1:0]   prod_fix;
  logic [XLEN-1:0] div_sel, div_fix, result_d;

  // Accept-side decode: magnitudes, result sign, special cases.
  always_comb begin
    op_e     = muldiv_op_e'(op_i);
    sa       = is_signed_a(op_e);
    sb       = is_signed_b(op_e);
    a_neg    = sa & a_i[XLEN-1];
    b_neg    = sb & b_i[XLEN-1];
    a_mag    = XLEN'(md_mag(MD_MAXW'(a_i), a_neg));
    b_mag    = XLEN'(md_mag(MD_MAXW'(b_i), b_neg));
    div_op   = is_div(op_e);
    rem_op   = is_rem(op_e);
    div_zero = div_op && (b_i == '0);
    ovf      = div_op && sa
            && (a_i == {1'b1, {(XLEN-1){1'b0}}})
            && (b_i == '1);
    special  = div_zero | ovf;
    res_neg  = rem_op ? a_neg : (a_neg ^ b_neg);
    if (div_zero)
      spec_res = rem_op ? a_i : '1;
    else
      spec_res = rem_op ? '0 : a_i;
  end

  // One iteration. Multiply: acc = {hi, multiplier}, add
  // and shift right. Divide: acc = {rem, dividend}, shift
  // left, restore on borrow.
  always_comb begin
    mul_sum  = {1'b0, acc_q[W2-1:XLEN]}
             + (acc_q[0] ? {1'b0, dvs_q} : '0);
    div_sh   = acc_q[W2-1:XLEN-1];
    div_diff = div_sh - {1'b0, dvs_q};
    if (is_div(op_q)) begin
      if (div_diff[XLEN])
        acc_d = {div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      else
        acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      acc_d = {mul_sum, acc_q[XLEN-1:1]};
    end
  end

  // Sign fix-up of the raw magnitude result.
  always_comb begin
    prod_fix = W2'(md_mag(MD_MAXW'(acc_q), neg_q));
    div_sel  = is_rem(op_q) ? acc_q[W2-1:XLEN]
                            : acc_q[XLEN-1:0];
    div_fix  = XLEN'(md_mag(MD_MAXW'(div_sel), neg_q));
    if (is_div(op_q))
      result_d = div_fix;
    else if (op_q == OP_MUL)
      result_d = prod_fix[XLEN-1:0];
    else
      result_d = prod_fix[W2-1:XLEN];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      op_q     <= OP_MUL;
      tag_q    <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      dvs_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else if (flush_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (valid_i) begin
            op_q  <= op_e;
            tag_q <= tag_i;
            neg_q <= res_neg;
            cnt_q <= '0;
            if (special) begin
              result_q <= spec_res;
              state_q  <= S_DONE;
            end else begin
              acc_q   <= {{XLEN{1'b0}}, a_mag};
              dvs_q   <= b_mag;
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CNT_LAST)
            state_q <= S_FIX;
        end
        S_FIX: begin
          result_q <= result_d;
          state_q  <= S_DONE;
        end
        S_DONE: begin
          if (ready_i)
            state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ready_o  = (state_q == S_IDLE);
  assign valid_o  = (state_q == S_DONE);
  assign result_o = result_q;
  assign tag_o    = tag_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit
// (XLEN=64) covering ops, special cases, stall, flush and reset.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        valid_i;
  logic        ready_o;
  logic [2:0]  op_i;
  logic [63:0] a_i;
  logic [63:0] b_i;
  logic [4:0]  tag_i;
  logic        flush_i;
  logic        valid_o;
  logic        ready_i;
  logic [63:0] result_o;
  logic [4:0]  tag_o;

  int ncmp  = 0;
  int nfail = 0;

  localparam logic [2:0] MUL   = 3'b000;
  localparam logic [2:0] MULH  = 3'b001;
  localparam logic [2:0] MULHU = 3'b011;
  localparam logic [2:0] DIV   = 3'b100;
  localparam logic [2:0] DIVU  = 3'b101;
  localparam logic [2:0] REM   = 3'b110;
  localparam logic [2:0] REMU  = 3'b111;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

  muldiv_unit #(.XLEN(64), .TAGW(5)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .op_i    (op_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .tag_i   (tag_i),
    .flush_i (flush_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .result_o(result_o),
    .tag_o   (tag_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [2:0] op,
                          input logic [63:0] a,
                          input logic [63:0] b,
                          input logic [4:0] tg);
    @(negedge clk);
    op_i = op; a_i = a; b_i = b; tag_i = tg;
    valid_i = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0;
  endtask

  // Negedges after the accept edge until valid_o is seen.
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (valid_o) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run(input logic [2:0] op,
                     input logic [63:0] a,
                     input logic [63:0] b,
                     input logic [4:0] tg,
                     output logic [63:0] res,
                     output logic [4:0] rtag,
                     output int lat);
    start_op(op, a, b, tg);
    wait_valid(lat);
    res  = result_o;
    rtag = tag_o;
  endtask

  logic [63:0] r;
  logic [4:0]  t;
  int          lat;
  int          vcnt;

  initial begin
    rst_ni  = 1'b0;
    valid_i = 1'b0;
    op_i    = '0;
    a_i     = '0;
    b_i     = '0;
    tag_i   = '0;
    flush_i = 1'b0;
    ready_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(ready_o), 64'd1);
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_result", result_o, 64'd0);
    check("rst_tag", 64'(tag_o), 64'd0);
    rst_ni = 1'b1;

    // MUL 7 * -3
    run(MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd9, r, t, lat);
    check("mul_res", r, 64'hFFFF_FFFF_FFFF_FFEB);
    check("mul_lat", 64'(lat), 64'd66);
    check("mul_tag", 64'(t), 64'd9);

    // Signed / unsigned division
    run(DIV, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5'd1, r, t, lat);
    check("div_res", r, 64'hFFFF_FFFF_FFFF_FFFA);
    check("div_lat", 64'(lat), 64'd66);
    run(REM, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5'd2, r, t, lat);
    check("rem_res", r, 64'hFFFF_FFFF_FFFF_FFFE);
    check("rem_tag", 64'(t), 64'd2);
    run(DIVU, 64'd100, 64'd7, 5'd3, r, t, lat);
    check("divu_res", r, 64'd14);
    run(REMU, 64'd100, 64'd7, 5'd4, r, t, lat);
    check("remu_res", r, 64'd2);

    // Divide by zero
    run(DIVU, 64'd5, 64'd0, 5'd5, r, t, lat);
    check("divz_res", r, ONES);
    check("divz_lat", 64'(lat), 64'd1);
    run(REM, 64'd5, 64'd0, 5'd6, r, t, lat);
    check("remz_res", r, 64'd5);
    check("remz_lat", 64'(lat), 64'd1);

    // Signed overflow
    run(DIV, MINV, ONES, 5'd7, r, t, lat);
    check("ovf_div_res", r, MINV);
    check("ovf_div_lat", 64'(lat), 64'd1);
    run(REM, MINV, ONES, 5'd8, r, t, lat);
    check("ovf_rem_res", r, 64'd0);
    check("ovf_rem_tag", 64'(t), 64'd8);

    // MULHU with consumer stall
    @(negedge clk);
    ready_i = 1'b0;
    run(MULHU, ONES, ONES, 5'd17, r, t, lat);
    check("mulhu_res", r, 64'hFFFF_FFFF_FFFF_FFFE);
    check("mulhu_tag", 64'(t), 64'd17);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_valid", 64'(valid_o), 64'd1);
      check("hold_res", result_o, 64'hFFFF_FFFF_FFFF_FFFE);
      check("hold_tag", 64'(tag_o), 64'd17);
      check("hold_ready", 64'(ready_o), 64'd0);
    end
    ready_i = 1'b1;
    @(negedge clk);
    check("rel_ready", 64'(ready_o), 64'd1);
    check("rel_valid", 64'(valid_o), 64'd0);

    // Flush on the 10th CALC cycle of a DIV
    start_op(DIV, 64'd1000, 64'd7, 5'd10);
    repeat (9) @(posedge clk);
    #1 flush_i = 1'b1;
    @(posedge clk);
    #1 flush_i = 1'b0;
    check("flush_ready", 64'(ready_o), 64'd1);
    check("flush_valid", 64'(valid_o), 64'd0);
    // A request coinciding with flush must not be taken.
    @(negedge clk);
    op_i = DIVU; a_i = 64'd9; b_i = 64'd3; tag_i = 5'd11;
    valid_i = 1'b1;
    flush_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    flush_i = 1'b0;
    check("flush_noacc", 64'(ready_o), 64'd1);
    vcnt = 0;
    repeat (80) begin
      @(negedge clk);
      if (valid_o) vcnt++;
    end
    check("flush_novalid", 64'(vcnt), 64'd0);
    run(MULH, ONES, ONES, 5'd12, r, t, lat);
    check("mulh_res", r, 64'd0);
    check("mulh_tag", 64'(t), 64'd12);

    // Asynchronous reset mid-CALC
    start_op(DIV, 64'd1000, 64'd7, 5'd13);
    repeat (9) @(posedge clk);
    #2 rst_ni = 1'b0;
    #1;
    check("arst_ready", 64'(ready_o), 64'd1);
    check("arst_valid", 64'(valid_o), 64'd0);
    check("arst_result", result_o, 64'd0);
    check("arst_tag", 64'(tag_o), 64'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    vcnt = 0;
    repeat (80) begin
      @(negedge clk);
      if (valid_o) vcnt++;
    end
    check("arst_novalid", 64'(vcnt), 64'd0);
    run(MULH, ONES, ONES, 5'd14, r, t, lat);
    check("mulh2_res", r, 64'd0);
    check("mulh2_tag", 64'(t), 64'd14);
    check("mulh2_lat", 64'(lat), 64'd66);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative integer multiply/divide unit, parametrised in operand width, implementing the eight RISC-V M-extension operations. It sits beside the EX-stage ALU: EX hands it an operation through a valid/ready handshake, and it returns the result plus a destination tag several cycles later. It also supports a pipeline flush, so a branch redirect can cancel an operation that is in flight.

## Interface
- XLEN, 64, operand/result width; any even value ≥ 8.
- TAGW, 5, width of the opaque tag (destination register index).
- clk_i  in  1  clock, all state updates on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- valid_i  in  1  request valid.
- ready_o  out  1  unit can accept a request; high only in IDLE.
- op_i  in  3  operation, encoded as funct3 (see Operation).
- a_i  in  XLEN  rs1 value.
- b_i  in  XLEN  rs2 value.
- tag_i  in  TAGW  tag, returned unchanged on tag_o.
- flush_i  in  1  cancel any in-flight or completed-but-unconsumed operation.
- valid_o  out  1  result valid.
- ready_i  in  1  consumer takes result.
- result_o  out  XLEN  result.
- tag_o  out  TAGW  tag of the result.

## Operation
- Op encoding:
  - 000 MUL: low XLEN bits of the product.
  - 001 MULH: high half, signed×signed.
  - 010 MULHSU: high half, signed a × unsigned b.
  - 011 MULHU: high half, unsigned×unsigned.
  - 100 DIV, 101 DIVU: quotient.
  - 110 REM, 111 REMU: remainder.
- Accept happens when valid_i && ready_o && !flush_i. On accept the unit latches op, tag, operand magnitudes and the result sign.
- Multiply is shift-add over the magnitudes, one bit per cycle, into a 2*XLEN accumulator.
- Divide is restoring, one quotient bit per cycle.
- FIX applies the sign. The quotient is negative iff the operand signs differ. The remainder takes the sign of a.
- Special cases are detected at accept and skip CALC and FIX:
  - Divide by zero: quotient = all ones; remainder = a_i.
  - Signed overflow (a = most-negative, b = −1): DIV = a_i; REM = 0.
- State machine (enum in package):
  - IDLE → CALC on a normal accept; IDLE → DONE on a special-case accept.
  - CALC → FIX after exactly XLEN iterations, counted by a $clog2(XLEN+1)-bit counter.
  - FIX → DONE.
  - DONE → IDLE when ready_i is high.
- flush_i has priority over everything. From any state it moves to IDLE at the next edge, the result is discarded and valid_o is low. A valid_i in the same cycle as flush_i is not accepted.
- Reset values:
  - State is IDLE.
  - ready_o = 1, valid_o = 0.
  - result_o = 0, tag_o = 0.
  - Counter and datapath registers are all 0.
- Reset asserted mid-operation aborts immediately, asynchronously; no result is produced.

## Timing
- Normal op: valid_o rises XLEN+2 cycles after the accept edge (XLEN CALC cycles, then 1 FIX cycle, then DONE registered). For XLEN = 64 this is 66 cycles.
- Special case: valid_o rises 1 cycle after the accept edge.
- While DONE and ready_i is low:
  - valid_o, result_o and tag_o hold stable.
  - ready_o stays low.
- Handshake completes in the cycle where valid_o && ready_i are both high. ready_o is high the following cycle, so the minimum back-to-back spacing is 1 idle cycle.
- result_o and tag_o are registered outputs, with no combinational path from inputs.
- ready_o and valid_o are decoded from the state register only.

## Structure
- Package muldiv_pkg holds:
  - muldiv_op_e: 3-bit op enum with the values above.
  - muldiv_state_e: IDLE, CALC, FIX, DONE.
  - Helper predicates is_div(op) and is_signed_a/b(op).
- A single module with no sub-module. Negation and magnitude are inline functions declared in the package.
- Intended instantiation is in EX, with flush_i tied to ex_pcsrc.

## Test plan
- MUL, XLEN = 64, a = 7, b = −3 → result 0xFFFF_FFFF_FFFF_FFEB; valid_o exactly 66 cycles after accept; tag 5'd9 returned.
- DIV −20/3 → 0xFFFF_FFFF_FFFF_FFFA (−6); REM −20/3 → 0xFFFF_FFFF_FFFF_FFFE (−2); DIVU 100/7 → 14; REMU 100/7 → 2.
- Divide by zero:
  - DIVU 5/0 → 0xFFFF_FFFF_FFFF_FFFF.
  - REM 5/0 → 5.
  - Both with valid_o 1 cycle after accept.
- Overflow: DIV 0x8000_0000_0000_0000 / −1 → 0x8000_0000_0000_0000, 1-cycle latency; REM with the same operands → 0.
- MULHU all-ones × all-ones → 0xFFFF_FFFF_FFFF_FFFE:
  - Hold ready_i low for 3 cycles; result_o, tag_o and valid_o stay stable.
  - ready_o becomes high 1 cycle after ready_i rises.
- Abort paths:
  - flush_i on the 10th CALC cycle of a DIV → valid_o never asserts; ready_o high next cycle. A following MULH −1 × −1 returns 0.
  - Repeat the same sequence with rst_ni pulsed low mid-CALC → outputs return to reset values asynchronously.
